alu_issue_unit: RTL
===================

ALU_ISSUE_UNIT -- requirements
Module: alu_issue_unit

Interface
REQ-001 SHALL have these ports, one clock domain:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous active-low reset
req_valid  in  1  operation request valid
req_ready  out  1  unit can accept a request this cycle
req_funsel  in  5  ALU function select, passed to the ALU unchanged
req_a  in  32  operand A
req_b  in  32  operand B
req_cin  in  1  explicit carry-in
req_cin_sel  in  1  carry source: 0 = req_cin, 1 = stored C flag
req_tag  in  4  opaque request ID, returned with the response
alu_a  out  32  to ALU input_a
alu_b  out  32  to ALU input_b
alu_funsel  out  5  to ALU FunSel
alu_cin  out  1  to ALU cin
alu_out  in  32  from ALU ALUOut
alu_flags  in  4  from ALU flags, {Z,C,N,V}
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer accepts the response
rsp_data  out  32  captured ALU result
rsp_flags  out  4  captured flags, {Z,C,N,V}
rsp_tag  out  4  tag of the request
flags_q  out  4  last completed flags, architectural status
ops_done  out  16  count of completed responses, wraps

Function
REQ-002 SHALL implement the FSM states IDLE, EXEC, RES, FLG and HOLD.
REQ-003 SHALL accept a request on a rising edge only when req_valid=1 and req_ready=1.
REQ-004 SHALL drive req_ready = (state==IDLE) | (state==HOLD & rsp_ready).
REQ-005 On accept, SHALL latch funsel, a, b, tag and the resolved carry (req_cin_sel ? flags_q[2] : req_cin), then go to EXEC.
REQ-006 SHALL drive alu_a, alu_b, alu_funsel and alu_cin from the latched values, holding them stable through EXEC, RES and FLG.
REQ-007 Transitions SHALL be EXEC->RES, then RES->FLG, each unconditional after one edge.
REQ-008 On the RES->FLG edge, SHALL capture alu_out into rsp_data.
REQ-009 On the FLG->HOLD edge, SHALL capture alu_flags into rsp_flags and flags_q, and increment ops_done.
REQ-010 SHALL hold rsp_valid=1 exactly while in HOLD.
REQ-011 rsp_valid SHALL rise 3 edges after the accept edge.
REQ-012 In HOLD with rsp_ready=0, SHALL keep rsp_data, rsp_flags and rsp_tag stable.
REQ-013 HOLD with rsp_ready=1 and req_valid=0 SHALL go to IDLE.
REQ-014 HOLD with rsp_ready=1 and req_valid=1 SHALL accept the new request and go directly to EXEC, giving a sustained throughput of one operation per 4 cycles.
REQ-015 With req_cin_sel=1 on a back-to-back accept from HOLD, the carry SHALL be taken from flags_q as already updated by the completing operation.
REQ-016 In IDLE, alu_* outputs SHALL hold their last latched values.
REQ-017 ops_done SHALL wrap from 0xFFFF to 0x0000.
REQ-018 flags_q SHALL change only on the FLG->HOLD edge.

Reset
REQ-019 Reset low SHALL asynchronously force state=IDLE.
REQ-020 Reset low SHALL clear all latched fields, rsp_data, rsp_flags, rsp_tag, flags_q and ops_done to 0, giving rsp_valid=0, req_ready=0 while reset is low, and all alu_* outputs = 0.
REQ-021 Reset asserted mid-operation SHALL discard the in-flight operation, with no response and no counter increment.
REQ-022 The first accept SHALL be possible on the first rising edge after reset deasserts.

Structure
REQ-023 A shared package alu_issue_pkg SHALL hold the state enum, the flag bit indices (Z=3, C=2, N=1, V=0) and the FunSel opcode constants (e.g. ADD32=5'b10100, ADC32=5'b10101, SUB32=5'b10110).
REQ-024 SHALL be a single flat module with no sub-module; the ALU is instantiated alongside it by the parent.

Verification
REQ-025 Bench SHALL cover: ADD32, a=0xFFFFFFFF, b=0x00000001 -> rsp_data=0x00000000, rsp_flags=4'b1100, rsp_valid 3 edges after accept.
REQ-026 Bench SHALL cover: ADD32 0xFFFFFFFF+1, then ADC32 a=5, b=6, req_cin_sel=1, back-to-back -> alu_cin=1, rsp_data=0x0000000C, flags_q[2] used.
REQ-027 Bench SHALL cover: rsp_ready=0 for 10 cycles in HOLD -> rsp_* stable, req_ready=0, ops_done incremented once.
REQ-028 Bench SHALL cover: three requests with tags 1, 2, 3 and rsp_ready tied to 1 -> responses every 4 cycles with tags in order 1, 2, 3.
REQ-029 Bench SHALL cover: reset pulled low during RES -> no response, ops_done=0, flags_q=0, next request completes normally.
REQ-030 Bench SHALL cover: ops_done forced near wrap (65535 ops, or via a bench force) -> ops_done reads 0x0000 after the next completion.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared types and constants for the ALU issue unit: FSM states, flag bit
// positions and ALU FunSel opcodes.
package alu_issue_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_EXEC = 3'd1,
      ST_RES  = 3'd2,
      ST_FLG  = 3'd3,
      ST_HOLD = 3'd4
   } state_t;

   localparam int unsigned FLAG_Z = 3;
   localparam int unsigned FLAG_C = 2;
   localparam int unsigned FLAG_N = 1;
   localparam int unsigned FLAG_V = 0;

   localparam logic [4:0] FS_ADD32 = 5'b10100;
   localparam logic [4:0] FS_ADC32 = 5'b10101;
   localparam logic [4:0] FS_SUB32 = 5'b10110;

   typedef struct packed {
      logic [4:0]  funsel;
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic [3:0]  tag;
   } op_t;

endpackage

// File: rtl/alu_issue_unit.sv
// Issues one operation at a time to an external ALU, captures its result and
// flags, and holds the response until the consumer accepts it.
module alu_issue_unit
   import alu_issue_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [4:0]  req_funsel,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   input  logic        req_cin,
   input  logic        req_cin_sel,
   input  logic [3:0]  req_tag,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [4:0]  alu_funsel,
   output logic        alu_cin,
   input  logic [31:0] alu_out,
   input  logic [3:0]  alu_flags,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic [3:0]  rsp_flags,
   output logic [3:0]  rsp_tag,
   output logic [3:0]  flags_q,
   output logic [15:0] ops_done
);

   state_t      state_q, state_d;
   op_t         op_q, op_d;
   logic [31:0] rsp_data_q, rsp_data_d;
   logic [3:0]  rsp_flags_q, rsp_flags_d;
   logic [3:0]  flags_d;
   logic [15:0] ops_done_q, ops_done_d;
   logic        accept;

   always_comb begin
      // Gated by reset so nothing looks acceptable while the unit is held in reset.
      req_ready   = reset & ((state_q == ST_IDLE) | ((state_q == ST_HOLD) & rsp_ready));
      accept      = req_valid & req_ready;
      state_d     = state_q;
      op_d        = op_q;
      rsp_data_d  = rsp_data_q;
      rsp_flags_d = rsp_flags_q;
      flags_d     = flags_q;
      ops_done_d  = ops_done_q;

      case (state_q)
         ST_IDLE: if (accept) state_d = ST_EXEC;
         ST_EXEC: state_d = ST_RES;
         ST_RES: begin
            state_d    = ST_FLG;
            rsp_data_d = alu_out;
         end
         ST_FLG: begin
            state_d     = ST_HOLD;
            rsp_flags_d = alu_flags;
            flags_d     = alu_flags;
            ops_done_d  = ops_done_q + 16'd1;
         end
         ST_HOLD: if (rsp_ready) state_d = accept ? ST_EXEC : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // In HOLD, flags_q already carries the completing op's flags.
      if (accept) begin
         op_d.funsel = req_funsel;
         op_d.a      = req_a;
         op_d.b      = req_b;
         op_d.cin    = req_cin_sel ? flags_q[FLAG_C] : req_cin;
         op_d.tag    = req_tag;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         op_q        <= '0;
         rsp_data_q  <= '0;
         rsp_flags_q <= '0;
         flags_q     <= '0;
         ops_done_q  <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         rsp_data_q  <= rsp_data_d;
         rsp_flags_q <= rsp_flags_d;
         flags_q     <= flags_d;
         ops_done_q  <= ops_done_d;
      end
   end

   assign alu_a      = op_q.a;
   assign alu_b      = op_q.b;
   assign alu_funsel = op_q.funsel;
   assign alu_cin    = op_q.cin;
   assign rsp_valid  = (state_q == ST_HOLD);
   assign rsp_data   = rsp_data_q;
   assign rsp_flags  = rsp_flags_q;
   assign rsp_tag    = op_q.tag;
   assign ops_done   = ops_done_q;

endmodule
